alu_station: RTL and testbench
==============================

// Module: alu_station
// PURPOSE
//   Reservation station feeding the ALU execution unit in the out-of-order core.
//   Holds dispatched ALU/branch/jump ops until both operands are resolved.
//   Snoops the ALU and LSB result buses for missing operands.
//   Issues at most one ready op per cycle on the ALU's calc_enable/lhs/rhs/op/rob_dep inputs.
// PARAMETERS
//   RS_SIZE    8  number of station entries (power of two, >=2)
//   ROB_WIDTH  4  width of ROB tags
//   OP_WIDTH   9  width of the internal opcode, same encoding the ALU decodes
// PORTS
//   clk_in          in   1          system clock; all state on posedge
//   rst_n_in        in   1          reset; asynchronous, active-low
//   rdy_in          in   1          global ready; all state holds when low
//   clear           in   1          misprediction flush
//   dispatch_valid  in   1          write new entry this cycle
//   dispatch_op     in   OP_WIDTH   opcode
//   dispatch_rob_id in   ROB_WIDTH  destination ROB tag
//   dispatch_vj     in   32         lhs value; meaningful when qj_valid=0
//   dispatch_qj_valid in 1          lhs pending on tag dispatch_qj
//   dispatch_qj     in   ROB_WIDTH  lhs producer tag
//   dispatch_vk     in   32         rhs value; immediates arrive here with qk_valid=0
//   dispatch_qk_valid in 1          rhs pending on tag dispatch_qk
//   dispatch_qk     in   ROB_WIDTH  rhs producer tag
//   full            out  1          combinational; all RS_SIZE entries busy
//   alu_res_valid   in   1          ALU result broadcast valid
//   alu_res_rob_id  in   ROB_WIDTH  ALU result tag
//   alu_res_value   in   32         ALU result value
//   lsb_res_valid   in   1          load/store buffer result broadcast valid
//   lsb_res_rob_id  in   ROB_WIDTH  LSB result tag
//   lsb_res_value   in   32         LSB result value
//   calc_enable     out  1          registered; issue strobe to the ALU
//   lhs, rhs        out  32 each    registered operands
//   op              out  OP_WIDTH   registered opcode
//   rob_dep         out  ROB_WIDTH  registered destination tag
// BEHAVIOUR
//   Reset (async on rst_n_in low): all entry busy bits = 0.
//     calc_enable, lhs, rhs, op, rob_dep = 0; full = 0.
//   Entry state: busy, op, rob_id, vj, qj, qj_valid, vk, qk, qk_valid.
//     ready = busy & ~qj_valid & ~qk_valid.
//   Every posedge with rdy_in=1 and clear=0, steps 1-3 use pre-edge state:
//   1. Issue: pick the lowest-index ready entry.
//      Drive calc_enable=1 and its op, vj, vk, rob_id; clear its busy bit.
//      If no entry is ready, calc_enable=0; lhs/rhs/op/rob_dep hold their old values.
//   2. Capture: any busy entry whose pending qj/qk matches a valid broadcast tag
//      takes that value and clears its pending bit.
//      If both buses carry the same tag, the ALU bus wins (illegal; ROB tags are unique).
//   3. Dispatch: if dispatch_valid & ~full, write the lowest-index non-busy entry.
//      Pre-edge free entries only; the slot freed by this cycle's issue is not reused.
//      Same-cycle bypass: a dispatched operand whose tag matches a valid broadcast
//      is stored resolved, with the broadcast value.
//      dispatch_valid while full: ignored, no state change; upstream must not do it.
//   Latency: an entry resolved at edge N issues at edge N+1 at the earliest.
//     Issue is one op per cycle, lowest index first (not age order).
//   A captured operand never makes its entry issue at the same edge.
//   clear=1 with rdy_in=1: all busy bits = 0 and calc_enable = 0 at that edge.
//     Dispatch and capture that cycle are discarded; lhs/rhs/op/rob_dep hold.
//   rdy_in=0: every register holds, including calc_enable.
//     The ALU ignores the strobe while rdy_in is low.
//   rst_n_in asserted mid-operation: immediate return to reset state; no partial issue.
// TESTING
//   T1 reset: assert rst_n_in=0 asynchronously mid-cycle
//      -> calc_enable=0, full=0, all outputs 0 before the next edge.
//   T2 dispatch ADD, vj=5, vk=7, both resolved, rob_id=3
//      -> next edge calc_enable=1, lhs=5, rhs=7, op=ADD, rob_dep=3, for exactly one cycle.
//   T3 dispatch SUB with qj=2 pending, vk=1; 2 cycles later alu_res rob 2 = 0x10
//      -> calc_enable stays 0 until the edge after capture, then lhs=0x10, rhs=1.
//   T4 dispatch qk=4 pending in the same cycle as lsb_res rob 4 = 9
//      -> issue next edge with rhs=9 (bypass).
//   T5 fill 8 entries pending on tag 6 -> full=1; a 9th dispatch is dropped.
//      Then broadcast tag 6 -> 8 issues on consecutive cycles, entries 0..7 in order.
//      full deasserts after the first issue.
//   T6a hold 3 resolved entries with rdy_in=0 for 3 cycles -> outputs frozen.
//   T6b then raise clear=1 with rdy_in=1
//      -> calc_enable=0, full=0, and nothing issues afterwards.

Source files
------------

// File: rtl/alu_station_if.sv
// Dispatch, result-broadcast and issue signals of the ALU reservation station.
// master drives dispatch/broadcasts (upstream + buses); slave is the station itself.
interface alu_station_if #(
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned OP_WIDTH  = 9
);
    logic                 dispatch_valid;
    logic [OP_WIDTH-1:0]  dispatch_op;
    logic [ROB_WIDTH-1:0] dispatch_rob_id;
    logic [31:0]          dispatch_vj;
    logic                 dispatch_qj_valid;
    logic [ROB_WIDTH-1:0] dispatch_qj;
    logic [31:0]          dispatch_vk;
    logic                 dispatch_qk_valid;
    logic [ROB_WIDTH-1:0] dispatch_qk;
    logic                 full;

    logic                 alu_res_valid;
    logic [ROB_WIDTH-1:0] alu_res_rob_id;
    logic [31:0]          alu_res_value;
    logic                 lsb_res_valid;
    logic [ROB_WIDTH-1:0] lsb_res_rob_id;
    logic [31:0]          lsb_res_value;

    logic                 calc_enable;
    logic [31:0]          lhs;
    logic [31:0]          rhs;
    logic [OP_WIDTH-1:0]  op;
    logic [ROB_WIDTH-1:0] rob_dep;

    modport master (
        output dispatch_valid, dispatch_op, dispatch_rob_id, dispatch_vj, dispatch_qj_valid,
        output dispatch_qj, dispatch_vk, dispatch_qk_valid, dispatch_qk,
        output alu_res_valid, alu_res_rob_id, alu_res_value,
        output lsb_res_valid, lsb_res_rob_id, lsb_res_value,
        input  full, calc_enable, lhs, rhs, op, rob_dep
    );

    modport slave (
        input  dispatch_valid, dispatch_op, dispatch_rob_id, dispatch_vj, dispatch_qj_valid,
        input  dispatch_qj, dispatch_vk, dispatch_qk_valid, dispatch_qk,
        input  alu_res_valid, alu_res_rob_id, alu_res_value,
        input  lsb_res_valid, lsb_res_rob_id, lsb_res_value,
        output full, calc_enable, lhs, rhs, op, rob_dep
    );
endinterface

// File: rtl/alu_station.sv
// Reservation station for the ALU: holds ops until operands resolve, snoops ALU/LSB
// result buses, and issues the lowest-index ready entry each cycle.
module alu_station #(
    parameter int unsigned RS_SIZE   = 8,
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned OP_WIDTH  = 9
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          rdy_in,
    input  logic          clear,
    alu_station_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0]   busy_q, qj_valid_q, qk_valid_q;
    logic [OP_WIDTH-1:0]  op_q     [RS_SIZE];
    logic [ROB_WIDTH-1:0] rob_id_q [RS_SIZE];
    logic [ROB_WIDTH-1:0] qj_q     [RS_SIZE];
    logic [ROB_WIDTH-1:0] qk_q     [RS_SIZE];
    logic [31:0]          vj_q     [RS_SIZE];
    logic [31:0]          vk_q     [RS_SIZE];

    logic                 calc_enable_q;
    logic [31:0]          lhs_q, rhs_q;
    logic [OP_WIDTH-1:0]  op_out_q;
    logic [ROB_WIDTH-1:0] rob_dep_q;

    logic [RS_SIZE-1:0]   ready;
    logic                 issue_found, free_found;
    logic [IdxW-1:0]      issue_idx, free_idx;
    logic [31:0]          disp_vj, disp_vk;
    logic                 disp_qj_valid, disp_qk_valid;

    assign ready = busy_q & ~qj_valid_q & ~qk_valid_q;

    // Descending scan so the lowest index wins.
    always_comb begin
        issue_found = 1'b0;
        issue_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (ready[i]) begin
                issue_found = 1'b1;
                issue_idx   = IdxW'(i);
            end
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
    end

    // Same-cycle bypass for dispatched operands; ALU bus takes priority.
    always_comb begin
        disp_vj       = bus.dispatch_vj;
        disp_qj_valid = bus.dispatch_qj_valid;
        disp_vk       = bus.dispatch_vk;
        disp_qk_valid = bus.dispatch_qk_valid;
        if (bus.dispatch_qj_valid) begin
            if (bus.alu_res_valid && bus.alu_res_rob_id == bus.dispatch_qj) begin
                disp_vj       = bus.alu_res_value;
                disp_qj_valid = 1'b0;
            end else if (bus.lsb_res_valid && bus.lsb_res_rob_id == bus.dispatch_qj) begin
                disp_vj       = bus.lsb_res_value;
                disp_qj_valid = 1'b0;
            end
        end
        if (bus.dispatch_qk_valid) begin
            if (bus.alu_res_valid && bus.alu_res_rob_id == bus.dispatch_qk) begin
                disp_vk       = bus.alu_res_value;
                disp_qk_valid = 1'b0;
            end else if (bus.lsb_res_valid && bus.lsb_res_rob_id == bus.dispatch_qk) begin
                disp_vk       = bus.lsb_res_value;
                disp_qk_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_q        <= '0;
            qj_valid_q    <= '0;
            qk_valid_q    <= '0;
            calc_enable_q <= 1'b0;
            lhs_q         <= '0;
            rhs_q         <= '0;
            op_out_q      <= '0;
            rob_dep_q     <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                op_q[i]     <= '0;
                rob_id_q[i] <= '0;
                qj_q[i]     <= '0;
                qk_q[i]     <= '0;
                vj_q[i]     <= '0;
                vk_q[i]     <= '0;
            end
        end else if (rdy_in) begin
            if (clear) begin
                busy_q        <= '0;
                calc_enable_q <= 1'b0;
            end else begin
                calc_enable_q <= issue_found;
                if (issue_found) begin
                    lhs_q             <= vj_q[issue_idx];
                    rhs_q             <= vk_q[issue_idx];
                    op_out_q          <= op_q[issue_idx];
                    rob_dep_q         <= rob_id_q[issue_idx];
                    busy_q[issue_idx] <= 1'b0;
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy_q[i] && qj_valid_q[i]) begin
                        if (bus.alu_res_valid && bus.alu_res_rob_id == qj_q[i]) begin
                            vj_q[i]       <= bus.alu_res_value;
                            qj_valid_q[i] <= 1'b0;
                        end else if (bus.lsb_res_valid && bus.lsb_res_rob_id == qj_q[i]) begin
                            vj_q[i]       <= bus.lsb_res_value;
                            qj_valid_q[i] <= 1'b0;
                        end
                    end
                    if (busy_q[i] && qk_valid_q[i]) begin
                        if (bus.alu_res_valid && bus.alu_res_rob_id == qk_q[i]) begin
                            vk_q[i]       <= bus.alu_res_value;
                            qk_valid_q[i] <= 1'b0;
                        end else if (bus.lsb_res_valid && bus.lsb_res_rob_id == qk_q[i]) begin
                            vk_q[i]       <= bus.lsb_res_value;
                            qk_valid_q[i] <= 1'b0;
                        end
                    end
                end
                // Free slot is chosen from pre-edge state, so it never aliases the issued one.
                if (bus.dispatch_valid && free_found) begin
                    busy_q[free_idx]     <= 1'b1;
                    op_q[free_idx]       <= bus.dispatch_op;
                    rob_id_q[free_idx]   <= bus.dispatch_rob_id;
                    vj_q[free_idx]       <= disp_vj;
                    qj_valid_q[free_idx] <= disp_qj_valid;
                    qj_q[free_idx]       <= bus.dispatch_qj;
                    vk_q[free_idx]       <= disp_vk;
                    qk_valid_q[free_idx] <= disp_qk_valid;
                    qk_q[free_idx]       <= bus.dispatch_qk;
                end
            end
        end
    end

    assign bus.full        = &busy_q;
    assign bus.calc_enable = calc_enable_q;
    assign bus.lhs         = lhs_q;
    assign bus.rhs         = rhs_q;
    assign bus.op          = op_out_q;
    assign bus.rob_dep     = rob_dep_q;
endmodule

// File: tb/tb_alu_station.sv
// Scoreboard bench for alu_station: a behavioural model queues expected issues and a
// negedge monitor compares them against the DUT's issue port.
module tb_alu_station;
    localparam int RS = 8;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b1;
    logic clear    = 1'b0;

    alu_station_if #(.ROB_WIDTH(4), .OP_WIDTH(9)) bus ();

    alu_station #(.RS_SIZE(8), .ROB_WIDTH(4), .OP_WIDTH(9)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .bus      (bus)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct {
        logic        busy;
        logic [8:0]  op;
        logic [3:0]  rob;
        logic [31:0] vj;
        logic        qjv;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic        qkv;
        logic [3:0]  qk;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [8:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [3:0]  rob;
    } iss_t;

    ent_t m[RS];
    iss_t exp_q[$];
    iss_t last;
    iss_t r_mon;
    logic m_ce;
    logic rdy_prev;
    logic fired;
    int   cyc;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand as seen through this cycle's broadcasts: {still_pending, value}.
    function automatic logic [32:0] snoop(input logic pend, input logic [3:0] tag,
                                          input logic [31:0] val);
        if (pend && bus.alu_res_valid && bus.alu_res_rob_id == tag)
            return {1'b0, bus.alu_res_value};
        if (pend && bus.lsb_res_valid && bus.lsb_res_rob_id == tag)
            return {1'b0, bus.lsb_res_value};
        return {pend, val};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS; i++) begin
            m[i].busy = 1'b0;
            m[i].qjv  = 1'b0;
            m[i].qkv  = 1'b0;
        end
        exp_q.delete();
        last     = '{0, '0, '0, '0, '0};
        m_ce     = 1'b0;
        rdy_prev = 1'b0;
    endtask

    task automatic model_step();
        ent_t        nx[RS];
        int          free_slot;
        logic [32:0] s;
        nx        = m;
        m_ce      = 1'b0;
        free_slot = -1;
        for (int i = 0; i < RS; i++) begin
            if (!m_ce && m[i].busy && !m[i].qjv && !m[i].qkv) begin
                m_ce = 1'b1;
                exp_q.push_back('{cyc, m[i].op, m[i].vj, m[i].vk, m[i].rob});
                nx[i].busy = 1'b0;
            end
        end
        for (int i = 0; i < RS; i++) begin
            if (m[i].busy) begin
                s = snoop(m[i].qjv, m[i].qj, m[i].vj);
                nx[i].qjv = s[32];
                nx[i].vj  = s[31:0];
                s = snoop(m[i].qkv, m[i].qk, m[i].vk);
                nx[i].qkv = s[32];
                nx[i].vk  = s[31:0];
            end
            if (free_slot < 0 && !m[i].busy) free_slot = i;
        end
        if (bus.dispatch_valid && free_slot >= 0) begin
            nx[free_slot].busy = 1'b1;
            nx[free_slot].op   = bus.dispatch_op;
            nx[free_slot].rob  = bus.dispatch_rob_id;
            nx[free_slot].qj   = bus.dispatch_qj;
            nx[free_slot].qk   = bus.dispatch_qk;
            s = snoop(bus.dispatch_qj_valid, bus.dispatch_qj, bus.dispatch_vj);
            nx[free_slot].qjv  = s[32];
            nx[free_slot].vj   = s[31:0];
            s = snoop(bus.dispatch_qk_valid, bus.dispatch_qk, bus.dispatch_vk);
            nx[free_slot].qkv  = s[32];
            nx[free_slot].vk   = s[31:0];
        end
        m = nx;
    endtask

    // Reference model.
    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk_in or negedge rst_n_in);
            if (!rst_n_in) begin
                model_reset();
            end else begin
                cyc++;
                rdy_prev = rdy_in;
                if (rdy_in) begin
                    if (clear) begin
                        for (int i = 0; i < RS; i++) m[i].busy = 1'b0;
                        m_ce = 1'b0;
                    end else begin
                        model_step();
                    end
                end
            end
        end
    end

    // Monitor.
    initial forever begin
        @(negedge clk_in);
        if (rst_n_in) begin
            fired = rdy_prev && bus.calc_enable;
            if (fired) begin
                if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL issue_spurious: cycle %0d got op=%0h lhs=%0h rhs=%0h rob=%0h, required no issue",
                             cyc, bus.op, bus.lhs, bus.rhs, bus.rob_dep);
                end else begin
                    r_mon = exp_q.pop_front();
                    check("issue", {bus.op, bus.lhs, bus.rhs, bus.rob_dep},
                          {r_mon.op, r_mon.lhs, r_mon.rhs, r_mon.rob});
                    last = r_mon;
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                r_mon = exp_q.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL issue_missing: cycle %0d got calc_enable=0, required op=%0h lhs=%0h rhs=%0h rob=%0h",
                         cyc, r_mon.op, r_mon.lhs, r_mon.rhs, r_mon.rob);
                last = r_mon;
            end else begin
                check("hold", {bus.calc_enable, bus.op, bus.lhs, bus.rhs, bus.rob_dep},
                      {m_ce, last.op, last.lhs, last.rhs, last.rob});
            end
        end
    end

    task automatic idle();
        bus.dispatch_valid = 1'b0;
        bus.alu_res_valid  = 1'b0;
        bus.lsb_res_valid  = 1'b0;
        clear              = 1'b0;
        rdy_in             = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk_in);
        idle();
    endtask

    task automatic disp(input logic [8:0] op, input logic [3:0] rob, input logic [31:0] vj,
                        input logic qjv, input logic [3:0] qj, input logic [31:0] vk,
                        input logic qkv, input logic [3:0] qk);
        bus.dispatch_valid    = 1'b1;
        bus.dispatch_op       = op;
        bus.dispatch_rob_id   = rob;
        bus.dispatch_vj       = vj;
        bus.dispatch_qj_valid = qjv;
        bus.dispatch_qj       = qj;
        bus.dispatch_vk       = vk;
        bus.dispatch_qk_valid = qkv;
        bus.dispatch_qk       = qk;
    endtask

    task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
        bus.alu_res_valid  = 1'b1;
        bus.alu_res_rob_id = tag;
        bus.alu_res_value  = val;
    endtask

    task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
        bus.lsb_res_valid  = 1'b1;
        bus.lsb_res_rob_id = tag;
        bus.lsb_res_value  = val;
    endtask

    initial begin
        idle();
        disp('0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        bus.dispatch_valid = 1'b0;
        alu_bc('0, '0);
        lsb_bc('0, '0);
        idle();
        repeat (3) @(negedge clk_in);
        check("reset_state", {bus.calc_enable, bus.op, bus.lhs, bus.rhs, bus.rob_dep, bus.full},
              '0);
        rst_n_in = 1'b1;

        // T2: resolved ADD
        tick(); disp(9'h001, 4'd3, 32'd5, 1'b0, 4'd0, 32'd7, 1'b0, 4'd0);
        repeat (3) tick();

        // T3: lhs pending on tag 2, resolved by ALU bus two cycles later
        tick(); disp(9'h002, 4'd5, 32'd0, 1'b1, 4'd2, 32'd1, 1'b0, 4'd0);
        tick();
        tick(); alu_bc(4'd2, 32'h10);
        repeat (3) tick();

        // T4: rhs bypassed from the LSB bus in the dispatch cycle
        tick(); disp(9'h003, 4'd7, 32'd3, 1'b0, 4'd0, 32'd0, 1'b1, 4'd4); lsb_bc(4'd4, 32'd9);
        repeat (3) tick();

        // T5: fill, drop the 9th, then release all in index order
        for (int i = 0; i < RS; i++) begin
            tick(); disp(9'h010 + 9'(i), 4'(i), 32'd0, 1'b1, 4'd6, 32'(i), 1'b0, 4'd0);
        end
        tick(); check("t5_full", bus.full, 1);
        disp(9'h0ff, 4'd15, 32'd1, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0);
        tick(); check("t5_full_after_drop", bus.full, 1);
        alu_bc(4'd6, 32'h66);
        tick();
        tick(); check("t5_full_release", bus.full, 0);
        repeat (9) tick();

        // T6: three resolved entries, freeze with rdy_in low, then flush
        for (int i = 0; i < 3; i++) begin
            tick(); disp(9'h020 + 9'(i), 4'(8 + i), 32'(100 + i), 1'b0, 4'd0, 32'(200 + i),
                         1'b1, 4'd9);
        end
        tick(); alu_bc(4'd9, 32'h99);
        tick();
        tick(); rdy_in = 1'b0;
        repeat (2) begin tick(); rdy_in = 1'b0; end
        tick(); clear = 1'b1;
        tick();
        check("t6_clear_ce", bus.calc_enable, 0);
        check("t6_clear_full", bus.full, 0);
        repeat (5) tick();
        check("t6_drain", exp_q.size(), 0);

        // Randomized traffic
        repeat (400) begin
            tick();
            rdy_in = ($urandom_range(9) != 0);
            clear  = ($urandom_range(39) == 0);
            if ($urandom_range(1) == 1)
                disp(9'($urandom), 4'($urandom), $urandom, $urandom_range(2) == 0,
                     4'($urandom_range(7)), $urandom, $urandom_range(2) == 0,
                     4'($urandom_range(7)));
            if ($urandom_range(2) == 0) alu_bc(4'($urandom_range(7)), $urandom);
            if ($urandom_range(2) == 0) lsb_bc(4'($urandom_range(7)), $urandom);
        end

        // T1: asynchronous reset mid-cycle
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("t1_async_reset",
              {bus.calc_enable, bus.op, bus.lhs, bus.rhs, bus.rob_dep, bus.full}, '0);
        tick();
        tick(); rst_n_in = 1'b1;
        repeat (4) tick();
        check("final_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
